error_accumulator: RTL and testbench
====================================

# error_accumulator

Batch mean-squared-error stage placed directly downstream of the 2-3-2 network's output layer. It consumes `out1`/`out2` together with target values, one sample per handshake. For each sample it emits registered, saturated per-output errors for the later weight-update logic. Over a batch of `BATCH` samples it accumulates squared errors and reports the batch MSE in the network's signed fixed-point format (Q(DWIDTH-frac).frac).

## Interface
- `DWIDTH`, 32, data width of network outputs, targets, errors and MSE
- `frac`, 24, fractional bits of the fixed-point format
- `BATCH`, 16, samples per batch; power of two, ≥2
- `ACCW`, 48, accumulator width; unsigned; must satisfy ACCW ≥ DWIDTH-1+log2(2·BATCH)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: reset, asynchronous, active-low
- `start` in 1: begin a batch; honoured only in IDLE
- `in_valid` in 1: `out1`, `out2`, `t1`, `t2` valid this cycle
- `in_ready` out 1: sample accepted when `in_valid & in_ready`
- `out1`, `out2` in DWIDTH signed: network outputs
- `t1`, `t2` in DWIDTH signed: targets
- `e1`, `e2` out DWIDTH signed: per-sample error, out − target, saturated
- `err_valid` out 1: `e1`/`e2` valid; 1-cycle pulse per accepted sample
- `busy` out 1: high in ACCUM and DRAIN
- `done` out 1: 1-cycle pulse; `mse` newly valid
- `mse` out DWIDTH signed: batch MSE, non-negative; held until the next `done`

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE → ACCUM on `start`. On that transition the accumulator and sample counter are cleared. `mse` is not cleared.
- ACCUM:
  - `in_ready` = 1.
  - Each accepted sample increments the counter.
  - On the BATCH-th accept, `in_ready` drops in the same clock edge and the FSM enters DRAIN.
- DRAIN: `in_ready` = 0. The FSM waits until the pipeline is empty. It then writes `mse`, pulses `done` and returns to IDLE.
- Error: the difference is computed at DWIDTH+1 bits, then clamped to [−2^(DWIDTH−1), 2^(DWIDTH−1)−1].
- Square:
  - The full 2·DWIDTH product e·e is arithmetically shifted right by `frac`.
  - The result is clamped to 2^(DWIDTH−1)−1.
  - The result is never negative.
- Accumulate: sq1+sq2 is added to the sum each valid cycle. The sum saturates at 2^ACCW−1 and never wraps.
- MSE: sum >> log2(2·BATCH), which is the mean over both outputs. The result is clamped to 2^(DWIDTH−1)−1.
- `start` while busy: ignored.
- `in_valid` in IDLE or DRAIN: ignored; no accept, no `err_valid`.
- `rst` low at any time: every register returns to its reset value immediately. An in-flight batch is discarded.

## Timing
- Reset values: `in_ready` 0, `busy` 0, `done` 0, `err_valid` 0, `e1`/`e2` 0, `mse` 0, FSM IDLE.
- `start` sampled at cycle S → `in_ready` and `busy` are 1 from S+1.
- Sample accepted at cycle N:
  - `e1`/`e2`/`err_valid` at N+1
  - squares registered at N+2
  - sum updated at N+3
- Throughput: one sample per cycle. `in_valid` gaps are allowed and are not counted.
- Last accept at cycle L:
  - `in_ready` is 0 from L+1.
  - `done` = 1 and `mse` updates at L+4.
  - `busy` = 0 from L+4.
  - A new `start` is honoured from L+4.
- `e1`/`e2` hold their last value when `err_valid` = 0.

## Structure
- Shared package `ann_pkg`:
  - DWIDTH and frac defaults
  - fixed-point constants ONE = 1<<frac, SMAX = 2^(DWIDTH−1)−1, SMIN
  - FSM state enum
- Sub-module `sat_square`: a registered e² with shift and clamp, instantiated twice. The FSM, counter, error stage and accumulator stay in `error_accumulator`.

## Test plan
(BATCH=4, Q8.24)
- All `out` = `t` = 0x01000000, 4 samples back-to-back → `e1`/`e2` = 0; `done` at L+4; `mse` = 0x00000000.
- `out1` = 0x01800000, `t1` = 0x01000000, `out2` = `t2`, 4 samples → `e1` = 0x00800000 each; sum = 0x01000000; `mse` = 0x00200000 (0.125).
- `out1` = 0x7FFFFFFF, `t1` = 0x80000000 → `e1` = 0x7FFFFFFF (clamped); square clamped to 0x7FFFFFFF; `mse` equals the clamped sum >> 3 with no wrap.
- `in_valid` toggled 1,0,1,0… then held high after the 4th accept → exactly 4 `err_valid` pulses; `in_ready` = 0 after the 4th; no 5th accept; `done` once.
- `start` re-pulsed during ACCUM → ignored, batch result unchanged. Previous `mse` holds until the next `done`.
- `rst` driven low after 2 accepts → all outputs at reset values immediately. A fresh batch then reproduces the scenario-2 result 0x00200000.

Source files
------------

// File: rtl/ann_pkg.sv
// ----------------------------------------------------------------------------
// ann_pkg
// Shared definitions for the 2-3-2 network datapath: default fixed-point
// format, fixed-point constants for that format and the error-accumulator
// FSM state encoding.
// ----------------------------------------------------------------------------
package ann_pkg;

  localparam int DWIDTH_DEF = 32;
  localparam int FRAC_DEF   = 24;

  // 1.0, most positive and most negative values in the default Q format
  localparam logic [DWIDTH_DEF-1:0] ONE  =
    {{(DWIDTH_DEF-FRAC_DEF-1){1'b0}}, 1'b1, {FRAC_DEF{1'b0}}};
  localparam logic [DWIDTH_DEF-1:0] SMAX = {1'b0, {(DWIDTH_DEF-1){1'b1}}};
  localparam logic [DWIDTH_DEF-1:0] SMIN = {1'b1, {(DWIDTH_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/sat_square.sv
// ----------------------------------------------------------------------------
// sat_square
// Registered fixed-point square: sq = clamp((e*e) >>> FRAC, SMAX).
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   en_i       load a new square this cycle
//   e_i        signed error input (DWIDTH)
//   sq_o       registered non-negative square (DWIDTH)
// ----------------------------------------------------------------------------
module sat_square
  import ann_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int FRAC   = FRAC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_i,
  input  logic signed [DWIDTH-1:0] e_i,
  output logic        [DWIDTH-1:0] sq_o
);

  localparam int PW = 2 * DWIDTH;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic                 ovf;
  logic [DWIDTH-1:0]    sq_d;
  logic [DWIDTH-1:0]    sq_q;

  // e*e is never negative, and even (-2^(DWIDTH-1))^2 fits in PW signed bits,
  // so any set bit at or above DWIDTH-1 after the shift means overflow.
  always_comb begin
    prod    = e_i * e_i;
    shifted = prod >>> FRAC;
    ovf     = |shifted[PW-1:DWIDTH-1];
    sq_d    = ovf ? {1'b0, {(DWIDTH-1){1'b1}}} : shifted[DWIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sq_q <= '0;
    end else if (en_i) begin
      sq_q <= sq_d;
    end
  end

  assign sq_o = sq_q;

endmodule

// File: rtl/error_accumulator.sv
// ----------------------------------------------------------------------------
// error_accumulator
// Batch MSE stage behind the network output layer. Per accepted sample it
// emits saturated errors e = out - target; over BATCH samples it sums both
// squared errors and reports mse = sum >> log2(2*BATCH), clamped.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start; mse holds the last batch result
//   ST_ACCUM | in_ready high, accepting samples until BATCH are taken
//   ST_DRAIN | in_ready low, waiting for error/square pipeline to empty
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   start                    begin a batch (IDLE only)
//   in_valid / in_ready      sample handshake
//   out1, out2, t1, t2       network outputs and targets (signed Q format)
//   e1, e2, err_valid        registered per-sample errors, 1-cycle valid
//   busy                     high in ACCUM and DRAIN
//   done, mse                1-cycle pulse with newly valid batch MSE
// Pipeline: accept N -> errors N+1 -> squares N+2 -> sum N+3.
// ----------------------------------------------------------------------------
module error_accumulator
  import ann_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int frac   = FRAC_DEF,
  parameter int BATCH  = 16,
  parameter int ACCW   = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DWIDTH-1:0] out1,
  input  logic signed [DWIDTH-1:0] out2,
  input  logic signed [DWIDTH-1:0] t1,
  input  logic signed [DWIDTH-1:0] t2,
  output logic signed [DWIDTH-1:0] e1,
  output logic signed [DWIDTH-1:0] e2,
  output logic                     err_valid,
  output logic                     busy,
  output logic                     done,
  output logic signed [DWIDTH-1:0] mse
);

  localparam int CW  = $clog2(BATCH);
  localparam int SHW = $clog2(2 * BATCH);

  localparam logic [DWIDTH-1:0] SMAX_W = {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] SMIN_W = {1'b1, {(DWIDTH-1){1'b0}}};

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic                       accept;
  logic                       last_accept;
  logic                       clr;
  logic                       fin;

  logic signed [DWIDTH-1:0]   e1_q, e2_q;
  logic                       err_valid_q;
  logic                       sq_valid_q;
  logic [DWIDTH-1:0]          sq1, sq2;

  logic [DWIDTH:0]            sq_sum;
  logic [ACCW:0]              sum_ext;
  logic [ACCW-1:0]            sum_q, sum_d;
  logic [ACCW-1:0]            sum_shr;
  logic [DWIDTH-1:0]          mse_d;
  logic signed [DWIDTH-1:0]   mse_q;
  logic                       done_q;

  // Difference at DWIDTH+1 bits; if the two top bits disagree the result does
  // not fit in DWIDTH bits and the sign bit picks the rail.
  function automatic logic [DWIDTH-1:0] sat_diff(input logic [DWIDTH-1:0] a,
                                                 input logic [DWIDTH-1:0] b);
    logic [DWIDTH:0] d;
    d = {a[DWIDTH-1], a} - {b[DWIDTH-1], b};
    if (d[DWIDTH] != d[DWIDTH-1]) begin
      sat_diff = d[DWIDTH] ? SMIN_W : SMAX_W;
    end else begin
      sat_diff = d[DWIDTH-1:0];
    end
  endfunction

  assign in_ready    = (state_q == ST_ACCUM);
  assign busy        = (state_q != ST_IDLE);
  assign accept      = in_valid & in_ready;
  assign last_accept = accept && (cnt_q == CW'(BATCH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr     = 1'b0;
    fin     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ACCUM;
          cnt_d   = '0;
          clr     = 1'b1;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (last_accept) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Both pipeline valids low means the last square is already in sum_q.
        if (!err_valid_q && !sq_valid_q) begin
          fin     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e1_q        <= '0;
      e2_q        <= '0;
      err_valid_q <= 1'b0;
      sq_valid_q  <= 1'b0;
    end else begin
      err_valid_q <= accept;
      sq_valid_q  <= err_valid_q;
      if (accept) begin
        e1_q <= sat_diff(out1, t1);
        e2_q <= sat_diff(out2, t2);
      end
    end
  end

  sat_square #(.DWIDTH(DWIDTH), .FRAC(frac)) u_sq1 (
    .clk  (clk),
    .rst  (rst),
    .en_i (err_valid_q),
    .e_i  (e1_q),
    .sq_o (sq1)
  );

  sat_square #(.DWIDTH(DWIDTH), .FRAC(frac)) u_sq2 (
    .clk  (clk),
    .rst  (rst),
    .en_i (err_valid_q),
    .e_i  (e2_q),
    .sq_o (sq2)
  );

  // Accumulator saturates at all-ones instead of wrapping; ACCW > DWIDTH+1 is
  // implied by the width requirement, so the cast below only zero-extends.
  always_comb begin
    sq_sum  = {1'b0, sq1} + {1'b0, sq2};
    sum_ext = {1'b0, sum_q} + (ACCW+1)'(sq_sum);
    sum_d   = sum_ext[ACCW] ? {ACCW{1'b1}} : sum_ext[ACCW-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum_q <= '0;
    end else if (clr) begin
      sum_q <= '0;
    end else if (sq_valid_q) begin
      sum_q <= sum_d;
    end
  end

  always_comb begin
    sum_shr = sum_q >> SHW;
    mse_d   = (|sum_shr[ACCW-1:DWIDTH-1]) ? SMAX_W : sum_shr[DWIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mse_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (fin) begin
        mse_q <= mse_d;
      end
    end
  end

  assign e1        = e1_q;
  assign e2        = e2_q;
  assign err_valid = err_valid_q;
  assign done      = done_q;
  assign mse       = mse_q;

endmodule

// File: tb/tb_error_accumulator.sv
// ----------------------------------------------------------------------------
// tb_error_accumulator
// Directed, table-driven bench for error_accumulator with BATCH=4, Q8.24.
// Each table group of four samples is one batch with a hand-computed MSE.
// ----------------------------------------------------------------------------
module tb_error_accumulator;

  localparam int DW    = 32;
  localparam int FR    = 24;
  localparam int BATCH = 4;
  localparam int ACCW  = 48;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 start = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] out1 = '0;
  logic signed [DW-1:0] out2 = '0;
  logic signed [DW-1:0] t1 = '0;
  logic signed [DW-1:0] t2 = '0;
  logic signed [DW-1:0] e1;
  logic signed [DW-1:0] e2;
  logic                 err_valid;
  logic                 busy;
  logic                 done;
  logic signed [DW-1:0] mse;

  error_accumulator #(
    .DWIDTH(DW), .frac(FR), .BATCH(BATCH), .ACCW(ACCW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .t1        (t1),
    .t2        (t2),
    .e1        (e1),
    .e2        (e2),
    .err_valid (err_valid),
    .busy      (busy),
    .done      (done),
    .mse       (mse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] o1;
    logic [31:0] o2;
    logic [31:0] t1;
    logic [31:0] t2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t        vecs[16];
  logic [31:0] exp_mse[4];
  logic [31:0] prev_mse;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] o1, input logic [31:0] tt1,
                              input logic [31:0] o2, input logic [31:0] tt2,
                              input logic [31:0] x1, input logic [31:0] x2);
    vec_t v;
    v.o1 = o1; v.t1 = tt1; v.o2 = o2; v.t2 = tt2; v.e1 = x1; v.e2 = x2;
    return v;
  endfunction

  // Runs one batch starting and ending #1 after a rising edge.
  task automatic run_batch(input int b, input bit gaps, input bit restart, input bit hold_valid);
    int lat;
    int extra;
    vec_t v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("in_ready_after_start", 32'(in_ready), 32'd1);
    check("busy_after_start", 32'(busy), 32'd1);
    check("mse_held_at_start", mse, prev_mse);
    for (int k = 0; k < BATCH; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("no_err_valid_in_gap", 32'(err_valid), 32'd0);
      end
      v = vecs[b*BATCH + k];
      out1 = v.o1; t1 = v.t1; out2 = v.o2; t2 = v.t2;
      in_valid = 1'b1;
      start = restart && (k == 2);
      @(posedge clk); #1;
      start = 1'b0;
      check("err_valid", 32'(err_valid), 32'd1);
      check("e1", e1, v.e1);
      check("e2", e2, v.e2);
      if (k < BATCH - 1) check("in_ready_mid_batch", 32'(in_ready), 32'd1);
    end
    check("in_ready_after_last", 32'(in_ready), 32'd0);
    check("mse_held_in_drain", mse, prev_mse);
    in_valid = hold_valid;
    lat = 1;
    extra = 0;
    while (done !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (err_valid !== 1'b0) extra++;
    end
    check("done_latency", 32'(lat), 32'd4);
    check("mse", mse, exp_mse[b]);
    check("busy_at_done", 32'(busy), 32'd0);
    check("extra_err_valid", 32'(extra), 32'd0);
    @(posedge clk); #1;
    check("done_single_pulse", 32'(done), 32'd0);
    check("no_accept_in_idle", 32'(err_valid), 32'd0);
    in_valid = 1'b0;
    prev_mse = exp_mse[b];
  endtask

  initial begin
    // batch 0: zero error
    for (int i = 0; i < 4; i++)
      vecs[i] = mk(32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0);
    exp_mse[0] = 32'h0000_0000;
    // batch 1: e1 = 0.5 each, sum 1.0, mse 0.125
    for (int i = 4; i < 8; i++)
      vecs[i] = mk(32'h0180_0000, 32'h0100_0000, 32'h0040_0000, 32'h0040_0000, 32'h0080_0000, 32'h0);
    exp_mse[1] = 32'h0020_0000;
    // batch 2: positive error clamp, square clamp, sum 4*SMAX >> 3
    for (int i = 8; i < 12; i++)
      vecs[i] = mk(32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h1234_5678, 32'h7FFF_FFFF, 32'h0);
    exp_mse[2] = 32'h3FFF_FFFF;
    // batch 3: negative clamp and -1.0, then three samples of e1 = 2.0
    vecs[12] = mk(32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0000, 32'h0100_0000, 32'h8000_0000, 32'hFF00_0000);
    for (int i = 13; i < 16; i++)
      vecs[i] = mk(32'h0200_0000, 32'h0000_0000, 32'h0, 32'h0, 32'h0200_0000, 32'h0);
    exp_mse[3] = 32'h119F_FFFF;
    prev_mse = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_e1", e1, 32'h0);
    check("rst_mse", mse, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_batch(0, 1'b0, 1'b0, 1'b0);
    run_batch(1, 1'b0, 1'b0, 1'b0);
    run_batch(2, 1'b0, 1'b0, 1'b0);
    run_batch(3, 1'b1, 1'b0, 1'b1);
    run_batch(1, 1'b0, 1'b1, 1'b0);

    // Reset in the middle of a batch
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      out1 = vecs[4+k].o1; t1 = vecs[4+k].t1; out2 = vecs[4+k].o2; t2 = vecs[4+k].t2;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    check("pre_rst_err_valid", 32'(err_valid), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err_valid", 32'(err_valid), 32'd0);
    check("mid_rst_e1", e1, 32'h0);
    check("mid_rst_e2", e2, 32'h0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_mse", mse, 32'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    prev_mse = 32'h0;
    @(posedge clk); #1;
    run_batch(1, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
